serial_link_tx: RTL and testbench
=================================

Name: serial_link_tx

Overview:
Single-clock serializer that drives one direction of a router-to-router serial link. It accepts one parallel flit (address + payload) per req handshake into a one-entry holding register. It launches a framed bit-serial transfer when the downstream channel is not busy: start bit, data LSB-first, even parity. It sits at a router output port, feeding the serial input of the neighbouring router's receive block.

Parameters:
ID, 0, instance number; debug $display only, no functional effect.
DIR, "east", port direction string; debug $display only.
DATA_W, `PAYLOAD_SIZE+`ADDR_SZ, flit width in bits; must be >= 2.

Ports:
clk  input  1  single clock; all state updates on posedge.
reset  input  1  synchronous, active-high.
req  input  1  flit-valid strobe; sampled each posedge.
parallel_in  input  DATA_W  flit; sampled when req accepted.
channel_busy  input  1  receiver cannot take a new frame; checked only at frame launch.
tx_busy  output  1  holding register full; req is not accepted while high.
serial_out  output  1  registered line; idle level 0.
tx_active  output  1  high during start, data and parity cycles.
overflow  output  1  one-cycle pulse when req arrives while tx_busy=1 (flit dropped).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset, sampled at posedge: state=IDLE, serial_out=0, tx_active=0, tx_busy=0, overflow=0, hold register cleared, bit counter=0.
- Reset mid-frame aborts the frame: line is 0 after that edge, and any held flit is discarded.
- Accept rule: at posedge with req=1 and tx_busy=0:
  - hold<=parallel_in; hold_valid<=1.
  - tx_busy = hold_valid, registered; it rises the cycle after acceptance.
- Drop rule: req=1 with tx_busy=1 leaves hold unchanged and sets overflow=1 for exactly one cycle.
- State machine: IDLE, START, DATA, PARITY.
- IDLE: at posedge with hold_valid=1 and channel_busy=0:
  - shreg<=hold; parity<=^hold; hold_valid<=0.
  - serial_out<=1 (start bit), tx_active<=1, go to START.
  - If channel_busy=1, wait; serial_out stays 0.
- START: serial_out<=shreg[0]; cnt<=0; go to DATA.
- DATA: each edge shifts shreg right.
  - If cnt<DATA_W-1: serial_out<=next bit; cnt<=cnt+1.
  - If cnt==DATA_W-1: serial_out<=parity; go to PARITY.
- PARITY: serial_out<=0; tx_active<=0; go to IDLE.
- Frame timing:
  - tx_active high exactly DATA_W+2 cycles.
  - Every frame is followed by at least one cycle of serial_out=0 before the next start bit.
- Latency: req accepted at edge E with the line idle and channel_busy=0:
  - hold_valid=1 after E.
  - Start bit appears after E+1.
  - First data bit after E+2.
- Simultaneous launch and accept at the same edge (launch empties hold while a new req is accepted): hold is refilled with the new flit and hold_valid stays 1.
- tx_busy is not asserted while hold is being emptied, so a back-to-back req in the launch cycle is accepted.
- channel_busy rising mid-frame has no effect; the frame completes.
- channel_busy is re-checked in IDLE before every launch.
- Parity is even: the parity bit equals the XOR of the DATA_W data bits.

Test Plan:
1. DATA_W=8, channel_busy=0; reset 4 cycles, then req with parallel_in=8'hA5 → serial_out from the launch edge reads 1,1,0,1,0,0,1,0,1,0 then 0; tx_active high 10 cycles; overflow never 1.
2. parallel_in=8'h01 → data bits 1,0,0,0,0,0,0,0; parity bit=1; start bit appears 2 edges after the req edge.
3. channel_busy=1 held 20 cycles with flit 8'h3C pending → serial_out=0 and tx_active=0 throughout, tx_busy=1; channel_busy drops → start bit on the next edge, parity=0.
4. Two reqs (8'h11, 8'h22) on consecutive cycles while line idle → both frames sent in order with exactly one idle cycle between; a third req while tx_busy=1 → overflow pulses 1 cycle, and that flit never appears on the line.
5. reset asserted during the 4th data bit of frame 8'hFF → after that edge serial_out=0, tx_active=0, tx_busy=0; a new req 8'h0F afterwards transmits correctly.
6. Random flits over 200 cycles with random channel_busy, checked by a bench deserializer → every accepted flit is received in order with correct parity; the count of drops equals the count of overflow pulses.

Source files
------------

// File: rtl/serial_link_tx.sv
// Flit serializer for one direction of a router-to-router link.
// Each frame is a start bit, then the data LSB-first, then an even-parity bit.
//
// state  | meaning
// IDLE   | line at 0; launch a held flit once channel_busy is low
// START  | start bit on the line; shreg holds the flit
// DATA   | data bits shifting out LSB-first
// PARITY | parity bit on the line; the next edge returns the line to 0

`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 6
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 2
`endif

module serial_link_tx #(
   parameter int ID     = 0,
   parameter     DIR    = "east",
   parameter int DATA_W = `PAYLOAD_SIZE + `ADDR_SZ
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic [DATA_W-1:0] parallel_in,
   input  logic              channel_busy,
   output logic              tx_busy,
   output logic              serial_out,
   output logic              tx_active,
   output logic              overflow
);

   localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   if (DATA_W < 2) begin : g_width_check
      $error("serial_link_tx %0d (%s): DATA_W must be at least 2", ID, DIR);
   end

   typedef enum logic [1:0] {IDLE, START, DATA, PARITY} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] hold, hold_nxt;
   logic [DATA_W-1:0] shreg, shreg_nxt;
   logic              hold_valid, hold_valid_nxt;
   logic              parity, parity_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              serial_nxt, active_nxt, busy_nxt, overflow_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         hold       <= '0;
         hold_valid <= 1'b0;
         shreg      <= '0;
         parity     <= 1'b0;
         cnt        <= '0;
         serial_out <= 1'b0;
         tx_active  <= 1'b0;
         tx_busy    <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_nxt;
         hold       <= hold_nxt;
         hold_valid <= hold_valid_nxt;
         shreg      <= shreg_nxt;
         parity     <= parity_nxt;
         cnt        <= cnt_nxt;
         serial_out <= serial_nxt;
         tx_active  <= active_nxt;
         tx_busy    <= busy_nxt;
         overflow   <= overflow_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      hold_nxt       = hold;
      hold_valid_nxt = hold_valid;
      shreg_nxt      = shreg;
      parity_nxt     = parity;
      cnt_nxt        = cnt;
      serial_nxt     = serial_out;
      active_nxt     = tx_active;
      // tx_busy lags hold_valid by one edge, so a req in the launch cycle still lands
      busy_nxt       = hold_valid;
      overflow_nxt   = req && tx_busy;

      case (state)
         IDLE: begin
            serial_nxt = 1'b0;
            if (hold_valid && !channel_busy) begin
               shreg_nxt      = hold;
               parity_nxt     = ^hold;
               hold_valid_nxt = 1'b0;
               serial_nxt     = 1'b1;
               active_nxt     = 1'b1;
               state_nxt      = START;
            end
         end
         START: begin
            serial_nxt = shreg[0];
            shreg_nxt  = shreg >> 1;
            cnt_nxt    = '0;
            state_nxt  = DATA;
         end
         DATA: begin
            if (cnt == LAST) begin
               serial_nxt = parity;
               state_nxt  = PARITY;
            end else begin
               serial_nxt = shreg[0];
               shreg_nxt  = shreg >> 1;
               cnt_nxt    = cnt + 1'b1;
            end
         end
         PARITY: begin
            serial_nxt = 1'b0;
            active_nxt = 1'b0;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // an accept in the launch cycle refills hold, overriding the clear above
      if (req && !tx_busy) begin
         hold_nxt       = parallel_in;
         hold_valid_nxt = 1'b1;
      end
   end

endmodule

// File: tb/tb_serial_link_tx.sv
// Directed and randomized checks of serial_link_tx framing, handshake, overflow and reset.
// Expected line values are hand-derived; the random phase uses a bench-side deserializer.

module tb_serial_link_tx;

   logic       clk = 1'b0;
   logic       reset, req, channel_busy;
   logic [7:0] parallel_in;
   logic       tx_busy, serial_out, tx_active, overflow;

   int ntotal = 0;
   int npass  = 0;

   logic        in_frame = 1'b0;
   int          bcnt = 0;
   logic [7:0]  rx = '0;
   logic [7:0]  exp_q[$];
   int          drops = 0, ovf_cnt = 0, frames = 0;
   logic        last_acc;
   logic [10:0] line_a5;

   serial_link_tx #(.ID(3), .DIR("west"), .DATA_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .parallel_in (parallel_in),
      .channel_busy(channel_busy),
      .tx_busy     (tx_busy),
      .serial_out  (serial_out),
      .tx_active   (tx_active),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Called with the start bit on the line; ends sampled after the frame's closing edge.
   task automatic check_frame(input logic [7:0] f, input string tag);
      chk({tag, "_start"}, serial_out, 1'b1);
      chk({tag, "_active_start"}, tx_active, 1'b1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("%s_bit%0d", tag, i), serial_out, f[i]);
         chk($sformatf("%s_active%0d", tag, i), tx_active, 1'b1);
      end
      tick();
      chk({tag, "_parity"}, serial_out, ^f);
      tick();
      chk({tag, "_idle"}, serial_out, 1'b0);
      chk({tag, "_active_end"}, tx_active, 1'b0);
   endtask

   task automatic observe();
      if (overflow) ovf_cnt++;
      if (!in_frame) begin
         if (serial_out) begin
            in_frame = 1'b1;
            bcnt     = 0;
            chk("rnd_active", tx_active, 1'b1);
         end
      end else if (bcnt < 8) begin
         rx[bcnt] = serial_out;
         bcnt++;
      end else begin
         in_frame = 1'b0;
         frames++;
         chk("rnd_parity", serial_out, ^rx);
         chk("rnd_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) chk("rnd_data", rx, exp_q.pop_front());
      end
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; channel_busy = 1'b0; parallel_in = '0;
      repeat (4) tick();
      chk("rst_serial", serial_out, 1'b0);
      chk("rst_active", tx_active, 1'b0);
      chk("rst_busy", tx_busy, 1'b0);
      chk("rst_overflow", overflow, 1'b0);

      // 1: 8'hA5 framed as 1,1,0,1,0,0,1,0,1,0 then idle
      reset = 1'b0; req = 1'b1; parallel_in = 8'hA5;
      tick();
      req = 1'b0;
      chk("t1_pre_launch_line", serial_out, 1'b0);
      chk("t1_busy_lags", tx_busy, 1'b0);
      tick();
      chk("t1_busy_after_launch", tx_busy, 1'b1);
      line_a5 = 11'b00101001011;
      for (int k = 0; k <= 10; k++) begin
         chk($sformatf("t1_line%0d", k), serial_out, line_a5[k]);
         chk($sformatf("t1_active%0d", k), tx_active, k < 10);
         chk($sformatf("t1_ovf%0d", k), overflow, 1'b0);
         if (k == 1) chk("t1_busy_clear", tx_busy, 1'b0);
         if (k < 10) tick();
      end

      // 2: 8'h01, start bit two edges after the req edge, parity 1
      req = 1'b1; parallel_in = 8'h01;
      tick();
      req = 1'b0;
      chk("t2_no_start_yet", serial_out, 1'b0);
      tick();
      check_frame(8'h01, "t2");

      // 3: 8'h3C held off by channel_busy for 20 cycles
      channel_busy = 1'b1; req = 1'b1; parallel_in = 8'h3C;
      tick();
      req = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk($sformatf("t3_line%0d", i), serial_out, 1'b0);
         chk($sformatf("t3_active%0d", i), tx_active, 1'b0);
         chk($sformatf("t3_busy%0d", i), tx_busy, 1'b1);
      end
      channel_busy = 1'b0;
      tick();
      check_frame(8'h3C, "t3");

      // 4: back-to-back 8'h11, 8'h22; a third req while busy is dropped
      req = 1'b1; parallel_in = 8'h11;
      tick();
      parallel_in = 8'h22;
      tick();
      chk("t4_start11", serial_out, 1'b1);
      chk("t4_busy", tx_busy, 1'b1);
      parallel_in = 8'h33;
      tick();
      req = 1'b0;
      chk("t4_overflow_pulse", overflow, 1'b1);
      chk("t4_bit0", serial_out, 1'b1);
      tick();
      chk("t4_overflow_one_cycle", overflow, 1'b0);
      chk("t4_bit1", serial_out, 1'b0);
      for (int i = 2; i < 8; i++) begin
         tick();
         chk($sformatf("t4_bit%0d", i), serial_out, i == 4);
      end
      tick();
      chk("t4_parity11", serial_out, 1'b0);
      tick();
      chk("t4_gap", serial_out, 1'b0);
      chk("t4_gap_active", tx_active, 1'b0);
      tick();
      check_frame(8'h22, "t4_22");
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("t4_quiet%0d", i), serial_out, 1'b0);
         chk($sformatf("t4_quiet_busy%0d", i), tx_busy, 1'b0);
      end

      // 5: reset during the 4th data bit of 8'hFF discards the frame and a held 8'hAA
      req = 1'b1; parallel_in = 8'hFF;
      tick();
      req = 1'b0;
      tick();
      chk("t5_start", serial_out, 1'b1);
      tick();
      chk("t5_busy_free", tx_busy, 1'b0);
      req = 1'b1; parallel_in = 8'hAA;
      tick();
      req = 1'b0;
      tick();
      chk("t5_busy_held", tx_busy, 1'b1);
      tick();
      chk("t5_bit3", serial_out, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_rst_line", serial_out, 1'b0);
      chk("t5_rst_active", tx_active, 1'b0);
      chk("t5_rst_busy", tx_busy, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("t5_after_rst%0d", i), serial_out, 1'b0);
      end
      req = 1'b1; parallel_in = 8'h0F;
      tick();
      req = 1'b0;
      tick();
      check_frame(8'h0F, "t5_0f");

      // 6: random flits and channel_busy against the bench deserializer
      last_acc = 1'b0;
      for (int c = 0; c < 200; c++) begin
         channel_busy = ($urandom_range(0, 3) == 0);
         req          = !last_acc && ($urandom_range(0, 2) == 0);
         parallel_in  = 8'($urandom);
         last_acc     = 1'b0;
         if (req) begin
            if (!tx_busy) begin
               exp_q.push_back(parallel_in);
               last_acc = 1'b1;
            end else begin
               drops++;
            end
         end
         tick();
         observe();
      end
      req = 1'b0; channel_busy = 1'b0;
      for (int c = 0; c < 60; c++) begin
         tick();
         observe();
      end
      chk("rnd_all_received", exp_q.size(), 0);
      chk("rnd_line_idle", in_frame, 1'b0);
      chk("rnd_drops_vs_overflow", ovf_cnt, drops);
      chk("rnd_some_frames", frames > 5, 1'b1);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
